// File: rtl/countdown_timer_tc_pkg.sv
// Shared types for the countdown timer: FSM state encoding and counter-core ops.
package countdown_timer_tc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Operation the FSM asks the counter core to perform on the next edge.
   typedef enum logic [1:0] {
      OP_HOLD   = 2'd0,
      OP_LOAD   = 2'd1,
      OP_DEC    = 2'd2,
      OP_RELOAD = 2'd3
   } cnt_op_e;

endpackage

// File: rtl/countdown_timer_tc_if.sv
// Control/status bundle of one countdown timer stage.
interface countdown_timer_tc_if #(parameter int WIDTH = 4);
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             start;
   logic             pause;
   logic             ce_in;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             busy;
   logic             done;

   modport master (output load, load_val, start, pause, ce_in,
                   input  q, tc, busy, done);
   modport slave  (input  load, load_val, start, pause, ce_in,
                   output q, tc, busy, done);
endinterface

// File: rtl/countdown_timer_tc_core.sv
// Down-counter core: holds Q and the RELOAD preset, applies load/decrement/reload,
// and flags Q==0 and RELOAD==0 for the controlling FSM.
module countdown_timer_tc_core
   import countdown_timer_tc_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  cnt_op_e          op_i,
   input  logic [WIDTH-1:0] load_val_i,
   output logic [WIDTH-1:0] q_o,
   output logic             zero_o,
   output logic             reload_zero_o
);

   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] reload_q, reload_d;

   // Next value of count and preset; the FSM never requests DEC at zero.
   always_comb begin
      q_d      = q_q;
      reload_d = reload_q;
      unique case (op_i)
         OP_LOAD: begin
            q_d      = load_val_i;
            reload_d = load_val_i;
         end
         OP_DEC:    q_d = q_q - WIDTH'(1);
         OP_RELOAD: q_d = reload_q;
         default:   ;
      endcase
   end

   // Count and preset registers, synchronous clear.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         q_q      <= '0;
         reload_q <= '0;
      end else begin
         q_q      <= q_d;
         reload_q <= reload_d;
      end
   end

   assign q_o           = q_q;
   assign zero_o        = (q_q == '0);
   assign reload_zero_o = (reload_q == '0);

endmodule

// File: rtl/countdown_timer_tc.sv
// Presettable cascadable down-counter with combinational terminal count.
// Cascade by feeding a lower stage's tc into the upper stage's ce_in.
module countdown_timer_tc
   import countdown_timer_tc_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter bit AUTO_RELOAD = 1'b0
) (
   input  logic              clk_i,
   input  logic              clr_i,
   countdown_timer_tc_if.slave bus_if
);

   state_e  state_q, state_d;
   cnt_op_e op;
   logic    zero, reload_zero;

   countdown_timer_tc_core #(.WIDTH(WIDTH)) u_core (
      .clk_i         (clk_i),
      .rst_i         (clr_i),
      .op_i          (op),
      .load_val_i    (bus_if.load_val),
      .q_o           (bus_if.q),
      .zero_o        (zero),
      .reload_zero_o (reload_zero)
   );

   // State register, synchronous clear.
   always_ff @(posedge clk_i) begin
      if (clr_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next state and counter op; LOAD beats PAUSE beats START beats counting.
   always_comb begin
      state_d = state_q;
      op      = OP_HOLD;
      if (bus_if.load) begin
         op      = OP_LOAD;
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (bus_if.start && !bus_if.pause)
                  state_d = zero ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
               if (bus_if.pause) begin
                  state_d = ST_HOLD;
               end else if (bus_if.ce_in) begin
                  if (!zero)            op      = OP_DEC;
                  else if (AUTO_RELOAD) op      = OP_RELOAD;
                  else                  state_d = ST_DONE;
               end
            end
            ST_HOLD: begin
               if (bus_if.start && !bus_if.pause) state_d = ST_RUN;
            end
            ST_DONE: begin
               // Restart from the preset; a zero preset leaves us parked in DONE.
               if (bus_if.start && !bus_if.pause) begin
                  op = OP_RELOAD;
                  if (!reload_zero) state_d = ST_RUN;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign bus_if.tc   = (state_q == ST_RUN) && bus_if.ce_in && zero;
   assign bus_if.busy = (state_q == ST_RUN) || (state_q == ST_HOLD);
   assign bus_if.done = (state_q == ST_DONE);

endmodule
